rans_byte_packer: RTL and testbench

- Downstream of the rANS encoder renormalisation stage: consumes one output byte per handshake and packs bytes little-endian into AXI-Stream words for the DMA S2MM path.
- Produces tkeep/tstrb for partial final words and tlast at frame end.
- Counts completed frames for the status register block.

---
 rtl/rans_pkg.sv | 28 ++
 rtl/rans_byte_packer.sv | 108 ++++++++++
 tb/tb_rans_byte_packer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rans_pkg.sv
// Shared constants, accumulator state type and lane-mask helper for the
// rANS byte packer.
package rans_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;
    localparam int unsigned LANES           = AXIS_DATA_WIDTH / 8;
    localparam int unsigned MAX_LANES       = 64;
    localparam int unsigned CNT_WIDTH       = $clog2(LANES + 1);

    // Accumulator contents for the default AXIS width.
    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic [CNT_WIDTH-1:0]       cnt;
        logic                       last;
        logic                       done;
    } acc_state_t;

    // (1 << cnt) - 1, saturating to all ones once cnt reaches MAX_LANES.
    function automatic logic [MAX_LANES-1:0] keep_mask(input logic [6:0] cnt);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < 32'(cnt));
        end
        return m;
    endfunction

endpackage

// File: rtl/rans_byte_packer.sv
// Packs encoder output bytes little-endian into AXI-Stream words with
// partial-word tkeep/tstrb, frame tlast and a completed-frame counter.
module rans_byte_packer
    import rans_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      s_byte_valid,
    output logic                      s_byte_ready,
    input  logic [7:0]                s_byte_data,
    input  logic                      s_byte_last,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                      m_axis_tlast,
    output logic [ID_WIDTH-1:0]       m_axis_tid,
    output logic [DEST_WIDTH-1:0]     m_axis_tdest,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic [31:0]               frame_count
);

    localparam int unsigned N_LANES = DATA_WIDTH / 8;
    localparam int unsigned CW      = $clog2(N_LANES + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [CW-1:0]         cnt;
        logic                  last;
        logic                  done;
    } acc_t;

    acc_t acc_q;
    acc_t acc_nxt;

    logic in_fire;
    logic out_fire;
    logic xfer;

    assign xfer         = acc_q.done & (~m_axis_tvalid | m_axis_tready);
    assign s_byte_ready = ~acc_q.done | xfer;
    assign in_fire      = s_byte_valid & s_byte_ready;
    assign out_fire     = m_axis_tvalid & m_axis_tready;

    // Handoff clears first so a byte arriving in the xfer cycle lands in lane 0.
    always_comb begin
        acc_nxt = acc_q;
        if (xfer) begin
            acc_nxt = '0;
        end
        if (in_fire) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                if (CW'(i) == acc_nxt.cnt) begin
                    acc_nxt.data[8*i +: 8] = s_byte_data;
                end
            end
            acc_nxt.cnt = acc_nxt.cnt + CW'(1);
            if ((acc_nxt.cnt == CW'(N_LANES)) || s_byte_last) begin
                acc_nxt.done = 1'b1;
                acc_nxt.last = s_byte_last;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (xfer) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= acc_q.data;
            m_axis_tkeep  <= N_LANES'(keep_mask(7'(acc_q.cnt)));
            m_axis_tlast  <= acc_q.last;
        end else if (out_fire) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
        end else if (out_fire && m_axis_tlast) begin
            frame_count <= frame_count + 32'd1;
        end
    end

    assign m_axis_tstrb = m_axis_tkeep;
    assign m_axis_tid   = '0;
    assign m_axis_tdest = '0;
    assign m_axis_tuser = '0;

endmodule

// File: tb/tb_rans_byte_packer.sv
// Scoreboard bench for rans_byte_packer: a byte-list packing model queues
// expected words on acceptance; an independent monitor checks emitted words.
module tb_rans_byte_packer;

    localparam int unsigned DW = 32;
    localparam int unsigned L  = DW / 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_byte_valid;
    logic          s_byte_ready;
    logic [7:0]    s_byte_data;
    logic          s_byte_last;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [L-1:0]  m_axis_tkeep;
    logic [L-1:0]  m_axis_tstrb;
    logic          m_axis_tlast;
    logic [0:0]    m_axis_tid;
    logic [0:0]    m_axis_tdest;
    logic [0:0]    m_axis_tuser;
    logic [31:0]   frame_count;

    rans_byte_packer #(
        .DATA_WIDTH(DW),
        .ID_WIDTH  (1),
        .DEST_WIDTH(1),
        .USER_WIDTH(1)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_byte_valid (s_byte_valid),
        .s_byte_ready (s_byte_ready),
        .s_byte_data  (s_byte_data),
        .s_byte_last  (s_byte_last),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tid   (m_axis_tid),
        .m_axis_tdest (m_axis_tdest),
        .m_axis_tuser (m_axis_tuser),
        .frame_count  (frame_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] d;
        logic [L-1:0]  k;
        logic          l;
    } word_t;

    word_t       expq[$];
    logic [7:0]  pend[$];
    int unsigned checks = 0;
    int unsigned fails  = 0;
    int unsigned exp_fc = 0;
    int unsigned words_seen = 0;
    int          tr_mode = 0;   // 0: ready, 1: random, 2: stalled
    logic        held = 1'b0;
    word_t       held_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: bytes of a word are concatenated in arrival order.
    function automatic void model_byte(input logic [7:0] b, input logic last);
        word_t w;
        pend.push_back(b);
        if (pend.size() == L || last) begin
            w.d = '0;
            for (int i = 0; i < pend.size(); i++) begin
                w.d = w.d | (DW'(pend[i]) << (8 * i));
            end
            w.k = L'((64'd1 << pend.size()) - 64'd1);
            w.l = last;
            expq.push_back(w);
            pend.delete();
        end
    endfunction

    always @(negedge aclk) begin
        case (tr_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: checks hold-stability, pops on handshake, tracks frame_count.
    initial begin
        word_t e;
        forever begin
            @(negedge aclk);
            #2;
            if (aresetn) begin
                if (held) begin
                    check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                    check("hold_tdata", 64'(m_axis_tdata), 64'(held_w.d));
                    check("hold_tkeep", 64'(m_axis_tkeep), 64'(held_w.k));
                    check("hold_tlast", 64'(m_axis_tlast), 64'(held_w.l));
                end
                held = 1'b0;
                if (m_axis_tvalid) begin
                    check("frame_count", 64'(frame_count), 64'(exp_fc));
                    check("tstrb_eq_tkeep", 64'(m_axis_tstrb), 64'(m_axis_tkeep));
                    if (m_axis_tready) begin
                        words_seen++;
                        if (expq.size() == 0) begin
                            check("unexpected_word", 64'(m_axis_tdata), 64'hDEAD_0000_0000);
                        end else begin
                            e = expq.pop_front();
                            check("tdata", 64'(m_axis_tdata), 64'(e.d));
                            check("tkeep", 64'(m_axis_tkeep), 64'(e.k));
                            check("tlast", 64'(m_axis_tlast), 64'(e.l));
                            if (e.l) exp_fc++;
                        end
                    end else begin
                        held   = 1'b1;
                        held_w.d = m_axis_tdata;
                        held_w.k = m_axis_tkeep;
                        held_w.l = m_axis_tlast;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int unsigned n = 0;
        @(negedge aclk);
        s_byte_valid = 1'b1;
        s_byte_data  = b;
        s_byte_last  = last;
        #1;
        while (!s_byte_ready && n < 300) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (!s_byte_ready) check("accept_timeout", 64'(s_byte_ready), 64'd1);
        else model_byte(b, last);
    endtask

    task automatic idle();
        @(negedge aclk);
        s_byte_valid = 1'b0;
        s_byte_last  = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((expq.size() != 0 || m_axis_tvalid) && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("drain_empty", 64'(expq.size()), 64'd0);
        repeat (3) @(negedge aclk);
    endtask

    task automatic send_frame(input int unsigned len, input logic [7:0] base);
        for (int unsigned i = 0; i < len; i++) begin
            send_byte(base + 8'(i), i == len - 1);
        end
    endtask

    initial begin
        int unsigned accepted;
        int unsigned w0;
        logic [7:0]  tbytes[4];
        aresetn      = 1'b0;
        s_byte_valid = 1'b0;
        s_byte_data  = '0;
        s_byte_last  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_ready", 64'(s_byte_ready), 64'd1);
        aresetn = 1'b1;

        // Single full frame, 6-byte frame, 1-byte frame.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        idle();
        drain();
        check("fc_after_first", 64'(frame_count), 64'd1);
        send_frame(6, 8'h01);
        idle();
        send_byte(8'hAB, 1'b1);
        idle();
        drain();
        check("fc_after_three", 64'(frame_count), 64'd3);

        // Backpressure: 12 bytes offered with tready held low.
        tr_mode  = 2;
        accepted = 0;
        @(negedge aclk);
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            s_byte_valid = (accepted < 12);
            s_byte_data  = 8'h20 + 8'(accepted);
            s_byte_last  = (accepted == 11);
            #1;
            if (s_byte_valid && s_byte_ready) begin
                model_byte(s_byte_data, s_byte_last);
                accepted++;
            end
        end
        check("bp_accepted", 64'(accepted), 64'd8);
        check("bp_ready_low", 64'(s_byte_ready), 64'd0);
        check("bp_tdata", 64'(m_axis_tdata), 64'h23222120);
        tr_mode = 0;
        for (int unsigned i = accepted; i < 12; i++) begin
            send_byte(8'h20 + 8'(i), i == 11);
        end
        idle();
        drain();

        // 64-byte continuous frame: ready must never drop.
        w0 = words_seen;
        for (int unsigned i = 0; i < 64; i++) begin
            @(negedge aclk);
            s_byte_valid = 1'b1;
            s_byte_data  = 8'($urandom);
            s_byte_last  = (i == 63);
            #1;
            check("stream_ready", 64'(s_byte_ready), 64'd1);
            if (s_byte_ready) model_byte(s_byte_data, s_byte_last);
        end
        idle();
        drain();
        check("stream_words", 64'(words_seen - w0), 64'd16);

        // Random frames under random tready.
        tr_mode = 1;
        for (int f = 0; f < 25; f++) begin
            int unsigned len;
            len = $urandom_range(1, 13);
            for (int unsigned i = 0; i < len; i++) begin
                send_byte(8'($urandom), i == len - 1);
                if ($urandom_range(0, 3) == 0) idle();
            end
        end
        idle();
        drain();
        tr_mode = 0;
        repeat (2) @(negedge aclk);
        check("fc_after_random", 64'(frame_count), 64'(exp_fc));

        // Reset mid-frame with a word pending at the output.
        tr_mode = 2;
        for (int unsigned i = 0; i < 6; i++) send_byte(8'h50 + 8'(i), 1'b0);
        idle();
        @(negedge aclk);
        check("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
        #3;
        aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_frame_count", 64'(frame_count), 64'd0);
        expq.delete();
        pend.delete();
        exp_fc = 0;
        held   = 1'b0;
        tr_mode = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        tbytes[0] = 8'hEF; tbytes[1] = 8'hBE; tbytes[2] = 8'hAD; tbytes[3] = 8'hDE;
        for (int i = 0; i < 4; i++) send_byte(tbytes[i], i == 3);
        idle();
        @(negedge aclk);
        #2;
        check("deadbeef_tdata", 64'(m_axis_tdata), 64'hDEADBEEF);
        check("deadbeef_tkeep", 64'(m_axis_tkeep), 64'hF);
        drain();
        check("fc_after_reset_frame", 64'(frame_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
